cpu_rf_mp: RTL and testbench
============================

# cpu_rf_mp

Parametrised multi-port register file for the CPU core, successor to the single-write, two-read file. Provides NRD registered read ports, two write ports (port A: ALU writeback, port B: memory/load writeback), same-cycle write-to-read bypass and a per-register busy scoreboard that tracks outstanding loads. Sits between decode (read) and writeback. A registered error pulse flags illegal write and scoreboard events.

## Interface
- DATA_W, 32, register width
- NREGS, 16, register count; power of two, ≥ 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports, ≥ 1
- ZERO_R0, 1, 1 = R0 hardwired to zero; 0 = R0 is general purpose

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_sel  in  NRD*AW  read selects, port i at bits [i*AW +: AW]
- rd_data  out  NRD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NRD  registered busy bit of each selected register
- wa_en / wa_sel / wa_data  in  1 / AW / DATA_W  write port A
- wb_en / wb_sel / wb_data  in  1 / AW / DATA_W  write port B; also clears the busy bit of wb_sel
- bs_en / bs_sel  in  1 / AW  set busy bit of bs_sel (load issued)
- err  out  1  registered one-cycle error pulse
- err_code  out  2  cause, valid while err = 1; 0 otherwise

## Operation
- Storage: NREGS × DATA_W flops, plus an NREGS-bit busy vector.
- Write: on a rising edge, reg[wa_sel] <= wa_data if wa_en, and reg[wb_sel] <= wb_data if wb_en.
- Collision: if both ports are enabled with wa_sel == wb_sel, port A wins. Both the stored and the forwarded value are wa_data.
- R0 with ZERO_R0=1: writes to R0 are discarded; reads of R0 always return 0 and rd_busy = 0; bs_en for R0 is ignored.
- Read: rd_data[i] <= effective value of reg[rd_sel[i]] after this edge's writes, so writes forward to a same-cycle read. Priority is port A, then port B, then stored value.
- Scoreboard: busy_next = busy, cleared at wb_sel if wb_en, then set at bs_sel if bs_en. Set wins over clear on the same register. Port A writes do not touch busy. rd_busy[i] <= busy_next[rd_sel[i]].
- Errors: err <= 1 for one cycle when any of the following hold. If several hold, the lowest code is reported.
  - code 1: ZERO_R0=1 and a write with nonzero data is enabled to R0 on either port.
  - code 2: wa_en & wb_en & wa_sel == wb_sel.
  - code 3: bs_en to a register whose current busy bit is 1 and that is not cleared by wb in the same cycle.
- Errors do not block the remaining side-effects of the cycle.

## Timing
- Reset (async assert, sync deassert by upstream): all registers 0, busy vector 0, rd_data 0, rd_busy 0, err 0, err_code 0. Reset mid-operation discards all state immediately.
- Read latency 1 cycle. rd_sel sampled at edge k appears on rd_data after edge k and reflects writes sampled at edge k.
- Write to read with bypass: 0 extra cycles. Without bypass, the value would appear one cycle later; bypass is mandatory.
- err and err_code are updated at the same edge as the offending write. The pulse is exactly 1 cycle unless the condition repeats.
- No internal state machine beyond storage and the scoreboard; every port is usable every cycle with no back-pressure.

## Test plan
- Reset: assert rst_n=0 mid-stream → all rd_data = 0, rd_busy = 0, err = 0 asynchronously; a read of R5 after release returns 0.
- Bypass: wa_en, wa_sel=3, wa_data=0xDEADBEEF with rd_sel port0=3 in the same cycle → rd_data[0] = 0xDEADBEEF on the next cycle. Holding rd_sel=3 afterwards keeps 0xDEADBEEF.
- Collision: wa (sel 7, 0x11) and wb (sel 7, 0x22) together → R7 = 0x11, the forwarded read = 0x11, err = 1 with code 2 for one cycle.
- R0 guard (ZERO_R0=1): wb_en sel 0 data 0x5 → err code 1, reading R0 gives 0. Writing data 0 to R0 → err = 0.
- Scoreboard: bs_en sel 4 → rd_busy = 1 for R4. Repeating bs_en sel 4 → err code 3. wb_en sel 4, 0xABCD → busy cleared and R4 = 0xABCD. Same-cycle wb_en sel 4 plus bs_en sel 4 → busy stays 1 and err = 0.
- Parameters: NREGS=32, NRD=3, DATA_W=64, ZERO_R0=0 → R0 is writable (0x123 reads back). Three ports read distinct registers in the same cycle, each matching its written value.

Source files
------------

// File: rtl/cpu_rf_mp.sv
// cpu_rf_mp: multi-port register file for the CPU core.
// NRD registered read ports, two write ports (A: ALU writeback, B: load
// writeback), same-cycle write-to-read forwarding, a per-register busy
// scoreboard for outstanding loads and a registered error pulse.
module cpu_rf_mp #(
   parameter int DATA_W  = 32,
   parameter int NREGS   = 16,
   parameter int NRD     = 2,
   parameter int ZERO_R0 = 1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NRD*AW-1:0]     rd_sel,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wa_en,
   input  logic [AW-1:0]         wa_sel,
   input  logic [DATA_W-1:0]     wa_data,
   input  logic                  wb_en,
   input  logic [AW-1:0]         wb_sel,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  bs_en,
   input  logic [AW-1:0]         bs_sel,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam logic [AW-1:0] R0_SEL = {AW{1'b0}};
   localparam bit            ZR     = (ZERO_R0 != 0);

   logic [DATA_W-1:0] regs_r    [NREGS];
   logic [DATA_W-1:0] regs_nx_s [NREGS];
   logic [NREGS-1:0]  busy_r;
   logic [NREGS-1:0]  busy_nx_s;
   logic              wa_eff_s;
   logic              wb_eff_s;
   logic              bs_eff_s;
   logic              e_r0_s;
   logic              e_coll_s;
   logic              e_busy_s;
   logic [1:0]        code_nx_s;

   // Qualify the write/set strobes: R0 guard and port-A-wins collision rule.
   always_comb begin
      wa_eff_s = wa_en & ~(ZR & (wa_sel == R0_SEL));
      wb_eff_s = wb_en & ~(ZR & (wb_sel == R0_SEL)) & ~(wa_en & (wa_sel == wb_sel));
      bs_eff_s = bs_en & ~(ZR & (bs_sel == R0_SEL));
   end

   // Post-write register image; reads index this so writes forward at once.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         if (wa_eff_s && (wa_sel == AW'(i))) begin
            regs_nx_s[i] = wa_data;
         end else if (wb_eff_s && (wb_sel == AW'(i))) begin
            regs_nx_s[i] = wb_data;
         end else begin
            regs_nx_s[i] = regs_r[i];
         end
      end
   end

   // Next busy vector: clear on load writeback, set on load issue (set wins).
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         if (bs_eff_s && (bs_sel == AW'(i))) begin
            busy_nx_s[i] = 1'b1;
         end else if (wb_en && (wb_sel == AW'(i))) begin
            busy_nx_s[i] = 1'b0;
         end else begin
            busy_nx_s[i] = busy_r[i];
         end
      end
   end

   // Error detection; lowest code wins when several causes coincide.
   always_comb begin
      e_r0_s   = ZR & ((wa_en & (wa_sel == R0_SEL) & (|wa_data)) |
                       (wb_en & (wb_sel == R0_SEL) & (|wb_data)));
      e_coll_s = wa_en & wb_en & (wa_sel == wb_sel);
      e_busy_s = bs_en & busy_r[bs_sel] & ~(wb_en & (wb_sel == bs_sel));
      if (e_r0_s) begin
         code_nx_s = 2'd1;
      end else if (e_coll_s) begin
         code_nx_s = 2'd2;
      end else if (e_busy_s) begin
         code_nx_s = 2'd3;
      end else begin
         code_nx_s = 2'd0;
      end
   end

   // Architectural storage: register array and busy scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         busy_r <= {NREGS{1'b0}};
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= regs_nx_s[i];
         end
         busy_r <= busy_nx_s;
      end
   end

   // Registered read ports and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= {(NRD*DATA_W){1'b0}};
         rd_busy  <= {NRD{1'b0}};
         err      <= 1'b0;
         err_code <= 2'd0;
      end else begin
         for (int i = 0; i < NRD; i++) begin
            rd_data[i*DATA_W +: DATA_W] <= regs_nx_s[rd_sel[i*AW +: AW]];
            rd_busy[i]                  <= busy_nx_s[rd_sel[i*AW +: AW]];
         end
         err      <= (code_nx_s != 2'd0);
         err_code <= code_nx_s;
      end
   end

endmodule

// File: tb/tb_cpu_rf_mp.sv
// tb_cpu_rf_mp: scoreboard bench for cpu_rf_mp. Instance u_dut uses the
// default parameters (R0 hardwired); u_wide uses NREGS=32, NRD=3,
// DATA_W=64, ZERO_R0=0.
module tb_cpu_rf_mp;

   logic        clk;
   logic        rst_n;

   logic [7:0]  rd_sel;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wa_en, wb_en, bs_en;
   logic [3:0]  wa_sel, wb_sel, bs_sel;
   logic [31:0] wa_data, wb_data;
   logic        err;
   logic [1:0]  err_code;

   logic [14:0]  p_rd_sel;
   logic [191:0] p_rd_data;
   logic [2:0]   p_rd_busy;
   logic         p_wa_en, p_wb_en, p_bs_en;
   logic [4:0]   p_wa_sel, p_wb_sel, p_bs_sel;
   logic [63:0]  p_wa_data, p_wb_data;
   logic         p_err;
   logic [1:0]   p_err_code;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] d0, d1;
      logic        b0, b1;
      logic        e;
      logic [1:0]  c;
   } exp_t;

   typedef struct {
      logic [63:0] d0, d1, d2;
      logic [2:0]  b;
      logic        e;
   } exp1_t;

   exp_t        q[$];
   exp1_t       q1[$];
   logic [31:0] m_regs [16];
   logic [15:0] m_busy;

   cpu_rf_mp u_dut (
      .clk(clk), .rst_n(rst_n),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd_busy(rd_busy),
      .wa_en(wa_en), .wa_sel(wa_sel), .wa_data(wa_data),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .bs_en(bs_en), .bs_sel(bs_sel),
      .err(err), .err_code(err_code)
   );

   cpu_rf_mp #(.DATA_W(64), .NREGS(32), .NRD(3), .ZERO_R0(0)) u_wide (
      .clk(clk), .rst_n(rst_n),
      .rd_sel(p_rd_sel), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
      .wa_en(p_wa_en), .wa_sel(p_wa_sel), .wa_data(p_wa_data),
      .wb_en(p_wb_en), .wb_sel(p_wb_sel), .wb_data(p_wb_data),
      .bs_en(p_bs_en), .bs_sel(p_bs_sel),
      .err(p_err), .err_code(p_err_code)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on u_dut, update the model, compare after the edge.
   task automatic step(input logic wae, input logic [3:0] was, input logic [31:0] wad,
                       input logic wbe, input logic [3:0] wbs, input logic [31:0] wbd,
                       input logic bse, input logic [3:0] bss,
                       input logic [3:0] r0, input logic [3:0] r1);
      exp_t e;
      logic [1:0] c;
      wa_en = wae; wa_sel = was; wa_data = wad;
      wb_en = wbe; wb_sel = wbs; wb_data = wbd;
      bs_en = bse; bs_sel = bss;
      rd_sel = {r1, r0};
      if ((wae && was == 4'd0 && wad != 32'd0) || (wbe && wbs == 4'd0 && wbd != 32'd0))
         c = 2'd1;
      else if (wae && wbe && was == wbs)
         c = 2'd2;
      else if (bse && m_busy[bss] && !(wbe && wbs == bss))
         c = 2'd3;
      else
         c = 2'd0;
      if (wbe && wbs != 4'd0) m_regs[wbs] = wbd;
      if (wae && was != 4'd0) m_regs[was] = wad;
      if (wbe) m_busy[wbs] = 1'b0;
      if (bse && bss != 4'd0) m_busy[bss] = 1'b1;
      e.d0 = m_regs[r0]; e.d1 = m_regs[r1];
      e.b0 = m_busy[r0]; e.b1 = m_busy[r1];
      e.e  = (c != 2'd0); e.c = c;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check_val("rd_data0", rd_data[31:0], e.d0);
      check_val("rd_data1", rd_data[63:32], e.d1);
      check_val("rd_busy0", rd_busy[0], e.b0);
      check_val("rd_busy1", rd_busy[1], e.b1);
      check_val("err", err, e.e);
      check_val("err_code", err_code, e.c);
      wa_en = 1'b0; wb_en = 1'b0; bs_en = 1'b0;
   endtask

   // Drive one cycle on u_wide with directed expectations.
   task automatic step1(input logic wae, input logic [4:0] was, input logic [63:0] wad,
                        input logic wbe, input logic [4:0] wbs, input logic [63:0] wbd,
                        input logic bse, input logic [4:0] bss,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2,
                        input logic [2:0] xb);
      exp1_t e;
      p_wa_en = wae; p_wa_sel = was; p_wa_data = wad;
      p_wb_en = wbe; p_wb_sel = wbs; p_wb_data = wbd;
      p_bs_en = bse; p_bs_sel = bss;
      p_rd_sel = {r2, r1, r0};
      e.d0 = x0; e.d1 = x1; e.d2 = x2; e.b = xb; e.e = 1'b0;
      q1.push_back(e);
      @(posedge clk);
      #1;
      e = q1.pop_front();
      check_val("wide_rd0", p_rd_data[63:0], e.d0);
      check_val("wide_rd1", p_rd_data[127:64], e.d1);
      check_val("wide_rd2", p_rd_data[191:128], e.d2);
      check_val("wide_busy", p_rd_busy, e.b);
      check_val("wide_err", p_err, e.e);
      p_wa_en = 1'b0; p_wb_en = 1'b0; p_bs_en = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_busy = 16'd0;
   endtask

   // Main stimulus sequence.
   initial begin
      rst_n = 1'b0;
      rd_sel = 8'd0; wa_en = 1'b0; wb_en = 1'b0; bs_en = 1'b0;
      wa_sel = 4'd0; wb_sel = 4'd0; bs_sel = 4'd0; wa_data = 32'd0; wb_data = 32'd0;
      p_rd_sel = 15'd0; p_wa_en = 1'b0; p_wb_en = 1'b0; p_bs_en = 1'b0;
      p_wa_sel = 5'd0; p_wb_sel = 5'd0; p_bs_sel = 5'd0; p_wa_data = 64'd0; p_wb_data = 64'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_rd", rd_data, 64'd0);
      check_val("reset_busy", rd_busy, 64'd0);
      check_val("reset_err", {err, err_code}, 64'd0);
      rst_n = 1'b1;

      // bypass and hold
      step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd0);
      check_val("bypass_const", rd_data[31:0], 64'hDEADBEEF);
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd3);
      // collision
      step(1'b1, 4'd7, 32'h11, 1'b1, 4'd7, 32'h22, 1'b0, 4'd0, 4'd7, 4'd3);
      check_val("coll_const", {err_code, rd_data[31:0]}, {30'd0, 2'd2, 32'h11});
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd7);
      // R0 guard
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h5, 1'b0, 4'd0, 4'd0, 4'd3);
      check_val("r0_const", {err_code, rd_data[31:0]}, {30'd0, 2'd1, 32'd0});
      step(1'b1, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0, 4'd0);
      // scoreboard
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd4, 4'd0);
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd4, 4'd0);
      check_val("sb_rebusy_code", err_code, 64'd3);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hABCD, 1'b0, 4'd0, 4'd4, 4'd0);
      check_val("sb_clear_const", {rd_busy[0], rd_data[31:0]}, {31'd0, 1'b0, 32'hABCD});
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 4'd4, 4'd0);
      step(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h77, 1'b1, 4'd4, 4'd4, 4'd0);
      check_val("sb_setwins_const", {err, rd_busy[0]}, {62'd0, 1'b0, 1'b1});
      // port A and port B to distinct registers; port A does not clear busy
      step(1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 4'd4, 4'd5);
      // mid-stream asynchronous reset
      step(1'b1, 4'd7, 32'h99, 1'b1, 4'd7, 32'h22, 1'b0, 4'd0, 4'd7, 4'd5);
      rst_n = 1'b0;
      #2;
      check_val("async_rst_rd", rd_data, 64'd0);
      check_val("async_rst_busy", rd_busy, 64'd0);
      check_val("async_rst_err", {err, err_code}, 64'd0);
      model_reset();
      rst_n = 1'b1;
      step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd4);
      check_val("post_rst_r5", rd_data[31:0], 64'd0);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // wide instance: R0 writable, three distinct read ports
      step1(1'b1, 5'd0, 64'h123, 1'b1, 5'd31, 64'hFEDC_BA98_7654_3210, 1'b0, 5'd0,
            5'd0, 5'd31, 5'd17, 64'h123, 64'hFEDC_BA98_7654_3210, 64'd0, 3'b000);
      step1(1'b1, 5'd17, 64'h1111_2222_3333_4444, 1'b1, 5'd9, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 5'd0,
            5'd0, 5'd17, 5'd9, 64'h123, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 3'b001);
      step1(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0,
            5'd9, 5'd0, 5'd31, 64'hAAAA_BBBB_CCCC_DDDD, 64'h123, 64'hFEDC_BA98_7654_3210, 3'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
